// File: rtl/decoder_seq.sv
// decoder_seq: registered binary-to-N decoder with four output codes.
// Direct mode decodes a select word taken through a valid/ready handshake.
// Scan mode walks its own index over every output with a programmable dwell,
// driving digit/row enables for multiplexed displays and keypads.
// OUT_W must equal 2**SEL_W so that every select code maps to one output bit.
module decoder_seq #(
    parameter int SEL_W   = 3,
    parameter int OUT_W   = 8,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   sel,
    input  logic [1:0]         mode,
    input  logic               scan_en,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   y,
    output logic               y_valid,
    output logic [SEL_W-1:0]   scan_idx
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

    state_t             state;
    logic               active;
    logic [SEL_W-1:0]   code_q;
    logic [DWELL_W-1:0] count;
    logic               code_new;
    logic [OUT_W-1:0]   decoded;

    // Maps a code to the selected output pattern; all variants derive from
    // the one-hot form so the four codes stay consistent with each other.
    function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] c,
                                                input logic [1:0]       m);
        logic [OUT_W-1:0] onehot;
        logic [OUT_W-1:0] res;
        onehot    = '0;
        onehot[c] = 1'b1;
        case (m)
            2'b00:   res = onehot;
            2'b01:   res = onehot >> 1;
            2'b10:   res = (onehot << 1) - ONE;
            2'b11:   res = ~onehot;
            default: res = onehot;
        endcase
        return res;
    endfunction

    assign decoded  = decode(code_q, mode);
    assign scan_idx = code_q;
    assign in_ready = !rst && (state == IDLE) && !scan_en;

    // Control FSM plus output register: y follows code_q and mode one cycle
    // later, and y_valid marks the first cycle y shows a freshly loaded code.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            active   <= 1'b0;
            code_q   <= '0;
            count    <= '0;
            code_new <= 1'b0;
            y        <= '0;
            y_valid  <= 1'b0;
        end else begin
            y        <= active ? decoded : '0;
            y_valid  <= code_new;
            code_new <= 1'b0;
            case (state)
                IDLE: begin
                    if (scan_en) begin
                        state    <= SCAN;
                        code_q   <= '0;
                        count    <= dwell;
                        active   <= 1'b1;
                        code_new <= 1'b1;
                    end else if (in_valid) begin
                        code_q   <= sel;
                        active   <= 1'b1;
                        code_new <= 1'b1;
                    end
                end
                SCAN: begin
                    if (!scan_en) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (count == '0) begin
                        code_q   <= code_q + 1'b1;
                        count    <= dwell;
                        code_new <= 1'b1;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: directed and randomized stimulus for decoder_seq, checked
// by a scoreboard fed from a behavioural model of the decoder.
module tb_decoder_seq;

    localparam int SEL_W   = 3;
    localparam int OUT_W   = 8;
    localparam int DWELL_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [SEL_W-1:0]   sel;
    logic [1:0]         mode;
    logic               scan_en;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   y;
    logic               y_valid;
    logic [SEL_W-1:0]   scan_idx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int code;
        int due;
    } exp_t;

    exp_t             expQ[$];
    int               cyc        = 0;
    bit               started    = 1'b0;
    bit               mScan      = 1'b0;
    bit               mActive    = 1'b0;
    int               mCode      = 0;
    int               scanCount  = 0;
    int               modeAtEdge = 0;
    logic [OUT_W-1:0] yExp       = '0;

    decoder_seq #(.SEL_W(SEL_W), .OUT_W(OUT_W), .DWELL_W(DWELL_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .mode     (mode),
        .scan_en  (scan_en),
        .dwell    (dwell),
        .y        (y),
        .y_valid  (y_valid),
        .scan_idx (scan_idx)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Reference decode written from the code tables with plain arithmetic.
    function automatic logic [OUT_W-1:0] refDecode(input int c, input int m);
        int v;
        case (m)
            0:       v = 1 << c;
            1:       v = (c == 0) ? 0 : (1 << (c - 1));
            2:       v = (1 << (c + 1)) - 1;
            default: v = (~(1 << c)) & ((1 << OUT_W) - 1);
        endcase
        return OUT_W'(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit v,
                                 input logic [SEL_W-1:0] s,
                                 input logic [1:0] m, input bit se,
                                 input logic [DWELL_W-1:0] d);
        rst      = r;
        in_valid = v;
        sel      = s;
        mode     = m;
        scan_en  = se;
        dwell    = d;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: tracks the decoded code per edge and queues every
    // new code with the cycle in which its y_valid pulse is due.
    always @(posedge clk) begin
        cyc++;
        modeAtEdge = int'(mode);
        if (rst) begin
            started   = 1'b1;
            expQ.delete();
            mScan     = 1'b0;
            mActive   = 1'b0;
            mCode     = 0;
            scanCount = 0;
            yExp      = '0;
        end else begin
            yExp = mActive ? refDecode(mCode, int'(mode)) : '0;
            if (mScan) begin
                if (!scan_en) begin
                    mScan = 1'b0;
                end else begin
                    scanCount++;
                    if (scanCount % (int'(dwell) + 1) == 0) begin
                        mCode = (scanCount / (int'(dwell) + 1)) % OUT_W;
                        expQ.push_back('{mCode, cyc + 1});
                    end
                end
            end else if (scan_en) begin
                mScan     = 1'b1;
                scanCount = 0;
                mCode     = 0;
                mActive   = 1'b1;
                expQ.push_back('{0, cyc + 1});
            end else if (in_valid) begin
                mCode   = int'(sel);
                mActive = 1'b1;
                expQ.push_back('{mCode, cyc + 1});
            end
        end
    end

    // Monitor: compares DUT outputs against the model away from the edge and
    // pops the scoreboard whenever a y_valid pulse is due.
    always @(negedge clk) begin
        bit   expValid;
        exp_t e;
        if (started) begin
            expValid = (expQ.size() > 0) && (expQ[0].due == cyc);
            checkOutput("y_valid", 32'(y_valid), 32'(expValid));
            if (expValid) begin
                e = expQ.pop_front();
                if (y_valid)
                    checkOutput("y_scoreboard", 32'(y),
                                32'(refDecode(e.code, modeAtEdge)));
            end
            checkOutput("y", 32'(y), 32'(yExp));
            checkOutput("scan_idx", 32'(scan_idx), mCode);
            checkOutput("in_ready", 32'(in_ready),
                        32'(!rst && !mScan && !scan_en));
        end
    end

    // Bounds the run in case the stimulus ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a randomized soak.
    initial begin
        logic [1:0]         curMode;
        bit                 curScan;
        logic [DWELL_W-1:0] curDwell;

        rst = 1'b1; in_valid = 1'b0; sel = '0; mode = '0;
        scan_en = 1'b0; dwell = '0;
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);

        $display("[TB] direct decode, one-hot");
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t1_ready_before", 32'(in_ready), 1);
        checkOutput("t1_y_before", 32'(y), 0);
        applyStimulus(0, 1, 5, 0, 0, 0);
        applyStimulus(0, 0, 5, 0, 0, 0);
        checkOutput("t1_y", 32'(y), 32'h20);
        checkOutput("t1_valid", 32'(y_valid), 1);

        $display("[TB] mode changes without handshake");
        applyStimulus(0, 0, 5, 1, 0, 0);
        checkOutput("t2_offset", 32'(y), 32'h10);
        checkOutput("t2_offset_valid", 32'(y_valid), 0);
        applyStimulus(0, 0, 5, 2, 0, 0);
        checkOutput("t2_thermo", 32'(y), 32'h3F);
        applyStimulus(0, 0, 5, 3, 0, 0);
        checkOutput("t2_activelow", 32'(y), 32'hDF);
        checkOutput("t2_activelow_valid", 32'(y_valid), 0);

        $display("[TB] back-to-back accepts, offset code");
        applyStimulus(0, 1, 0, 1, 0, 0);
        applyStimulus(0, 1, 7, 1, 0, 0);
        checkOutput("t3_first_y", 32'(y), 32'h00);
        checkOutput("t3_first_valid", 32'(y_valid), 1);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t3_second_y", 32'(y), 32'h40);
        checkOutput("t3_second_valid", 32'(y_valid), 1);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t3_valid_drop", 32'(y_valid), 0);

        $display("[TB] scan with dwell 2 and wrap");
        applyStimulus(0, 0, 0, 0, 1, 2);
        checkOutput("t4_ready_entry", 32'(in_ready), 0);
        for (int n = 1; n <= 27; n++) begin
            applyStimulus(0, 0, 0, 0, 1, 2);
            checkOutput("t4_walk_y", 32'(y), 1 << (((n - 1) / 3) % 8));
            checkOutput("t4_walk_valid", 32'(y_valid),
                        32'((n - 1) % 3 == 0));
            checkOutput("t4_ready", 32'(in_ready), 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 2);
        checkOutput("t4_ready_after", 32'(in_ready), 1);

        $display("[TB] scan beats simultaneous select");
        applyStimulus(0, 1, 3, 0, 1, 1);
        checkOutput("t5_idx", 32'(scan_idx), 0);
        applyStimulus(0, 0, 3, 0, 1, 1);
        checkOutput("t5_y", 32'(y), 32'h01);
        checkOutput("t5_valid", 32'(y_valid), 1);
        repeat (5) applyStimulus(0, 0, 3, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);

        $display("[TB] reset during scan");
        applyStimulus(0, 0, 0, 0, 1, 0);
        repeat (4) applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("t6_idx_before", 32'(scan_idx), 4);
        applyStimulus(1, 0, 0, 0, 1, 0);
        checkOutput("t6_y_reset", 32'(y), 0);
        checkOutput("t6_idx_reset", 32'(scan_idx), 0);
        checkOutput("t6_valid_reset", 32'(y_valid), 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t6_ready_idle", 32'(in_ready), 1);
        applyStimulus(0, 1, 2, 0, 0, 0);
        applyStimulus(0, 0, 2, 0, 0, 0);
        checkOutput("t6_y_after", 32'(y), 32'h04);
        checkOutput("t6_valid_after", 32'(y_valid), 1);

        $display("[TB] randomized soak");
        curMode  = 2'b00;
        curScan  = 1'b0;
        curDwell = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) curScan = !curScan;
            if (!curScan && $urandom_range(0, 3) == 0)
                curDwell = DWELL_W'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)
                curMode = 2'($urandom_range(0, 3));
            applyStimulus(1'($urandom_range(0, 49) == 0),
                          1'($urandom_range(0, 1)),
                          SEL_W'($urandom_range(0, OUT_W - 1)),
                          curMode, curScan, curDwell);
        end
        applyStimulus(0, 0, 0, curMode, 0, 0);
        applyStimulus(0, 0, 0, curMode, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
